multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Purpose: control FSM for a multicycle RV32 subset core (fetch/decode/exec/mem/wb).
// Latency: branch 3, ALU/LUI/store 4, load 5 cycles with zero memory wait.
// Backpressure: mem_ready low stalls FETCH and MEM; mem_req stays high until accepted.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        alu_src_imm,
    output logic [2:0]  imm_type,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        instret,
    output logic [31:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_OPIMM   = 3'd1,
        C_LOAD    = 3'd2,
        C_STORE   = 3'd3,
        C_BRANCH  = 3'd4,
        C_LUI     = 3'd5,
        C_RTYPE   = 3'd6
    } cls_t;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_NONE = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    state_t cur, nxt;
    cls_t   cls, dec_cls;

    // Only the opcode field matters to control; the rest feeds the datapath.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[31:7];

    assign state = cur;

    // Combinational opcode classification, captured into cls while in DECODE.
    always_comb begin
        dec_cls = C_ILLEGAL;
        case (inst[6:0])
            7'b0010011: dec_cls = C_OPIMM;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b0110111: dec_cls = C_LUI;
            7'b0110011: dec_cls = C_RTYPE;
            default:    dec_cls = C_ILLEGAL;
        endcase
    end

    // State, latched class, sticky illegal flag and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur           <= S_FETCH;
            cls           <= C_ILLEGAL;
            illegal       <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                cls <= dec_cls;
                if (dec_cls == C_ILLEGAL) begin
                    illegal <= 1'b1;
                end
            end
            if (instret) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    // Next-state and control outputs; later stages look only at the latched class.
    always_comb begin
        nxt          = cur;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        alu_src_imm  = 1'b0;
        imm_type     = IMM_NONE;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        instret      = 1'b0;

        if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
            case (cls)
                C_OPIMM, C_LOAD: begin imm_type = IMM_I; alu_src_imm = 1'b1; end
                C_STORE:         begin imm_type = IMM_S; alu_src_imm = 1'b1; end
                C_BRANCH:        imm_type = IMM_B;
                C_LUI:           imm_type = IMM_U;
                default:         imm_type = IMM_NONE;
            endcase
        end

        case (cur)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                nxt = (dec_cls == C_ILLEGAL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken;
                        instret = 1'b1;
                        nxt     = S_FETCH;
                    end
                    C_LOAD, C_STORE:         nxt = S_MEM;
                    C_OPIMM, C_RTYPE, C_LUI: nxt = S_WB;
                    default:                 nxt = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == C_STORE);
                if (mem_ready) begin
                    if (cls == C_STORE) begin
                        pc_we   = 1'b1;
                        instret = 1'b1;
                        nxt     = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                instret = 1'b1;
                nxt     = S_FETCH;
                if (cls == C_LOAD) begin
                    wb_sel = WB_MEM;
                end else if (cls == C_LUI) begin
                    wb_sel = WB_IMM;
                end
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase

        // Reset silences every strobe in the same cycle, even mid-handshake.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            instret = 1'b0;
            nxt     = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: scoreboard bench for multicycle_ctrl using directed instruction vectors.
// Latency: each vector runs for its hand-computed cycle count.
// Backpressure: mem_ready patterns insert wait cycles in FETCH and MEM.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        branch_taken;
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel;
    logic        alu_src_imm, reg_we, illegal, instret;
    logic [2:0]  imm_type;
    logic [1:0]  wb_sel;
    logic [31:0] retired_count;

    typedef struct {
        logic [2:0]  st;
        logic        pcw;
        logic        pcs;
        logic        rw;
        logic [1:0]  wbs;
        logic [2:0]  imm;
        logic        alu;
        logic        mwe;
        logic        mreq;
        logic [31:0] rc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_cnt = 0;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .state        (state),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_is_fetch (mem_is_fetch),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_src_imm  (alu_src_imm),
        .imm_type     (imm_type),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .instret      (instret),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic pcw, input logic pcs,
                                input logic rw, input logic [1:0] wbs, input logic [2:0] imm,
                                input logic alu, input logic mwe, input logic mreq,
                                input logic [31:0] rc, input int lat);
        exp_t e;
        e.st = st; e.pcw = pcw; e.pcs = pcs; e.rw = rw; e.wbs = wbs; e.imm = imm;
        e.alu = alu; e.mwe = mwe; e.mreq = mreq; e.rc = rc; e.lat = lat;
        return e;
    endfunction

    // Monitor: every retire pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc_cnt = 0;
        end else begin
            cyc_cnt++;
            if (instret) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instret", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_state",   32'(state),         32'(e.st));
                    chk("ret_pc_we",   32'(pc_we),         32'(e.pcw));
                    chk("ret_pc_sel",  32'(pc_sel),        32'(e.pcs));
                    chk("ret_reg_we",  32'(reg_we),        32'(e.rw));
                    chk("ret_wb_sel",  32'(wb_sel),        32'(e.wbs));
                    chk("ret_imm",     32'(imm_type),      32'(e.imm));
                    chk("ret_alu_imm", 32'(alu_src_imm),   32'(e.alu));
                    chk("ret_mem_we",  32'(mem_we),        32'(e.mwe));
                    chk("ret_mem_req", 32'(mem_req),       32'(e.mreq));
                    chk("ret_count",   retired_count,      e.rc);
                    chk("ret_latency", 32'(cyc_cnt),       32'(e.lat));
                end
                cyc_cnt = 0;
            end
        end
    end

    // Drives one instruction for n cycles; per-cycle bit k of rdy/mreq/mwe and
    // st[3k+:3] give the memory response and the expected state/request pattern.
    // After the DECODE cycle inst is overwritten to show the latched class is used.
    task automatic run(input string nm, input logic [31:0] i, input logic bt, input int n,
                       input logic [15:0] rdy, input logic [15:0] mreq, input logic [15:0] mwe,
                       input logic [23:0] st, input bit push, input exp_t e);
        logic [31:0] cur_i;
        cur_i = i;
        if (push) exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            inst         = cur_i;
            branch_taken = bt;
            mem_ready    = rdy[k];
            @(negedge clk);
            chk({nm, "_state"},   32'(state),   32'(st[3*k +: 3]));
            chk({nm, "_mem_req"}, 32'(mem_req), 32'(mreq[k]));
            chk({nm, "_mem_we"},  32'(mem_we),  32'(mwe[k]));
            if (st[3*k +: 3] == 3'd1) cur_i = 32'h0000007F;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; inst = 32'd0; mem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_count",   retired_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // addi: 0,1,2,4 with retire in WB
        run("addi", 32'h00500093, 1'b0, 4, 16'b1111, 16'b0001, 16'b0000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd4, 1, 0, 1, 2'd0, 3'd0, 1, 0, 0, 32'd0, 4));
        // addi with one FETCH wait cycle
        run("addi_fw", 32'h00500093, 1'b0, 5, 16'b11110, 16'b00011, 16'b00000,
            {3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0, 3'd0}, 1'b1,
            mk(3'd4, 1, 0, 1, 2'd0, 3'd0, 1, 0, 0, 32'd1, 5));
        // lw with two MEM wait cycles: mem_req held three MEM cycles
        run("lw", 32'h0000A103, 1'b0, 7, 16'b1100111, 16'b0111001, 16'b0000000,
            {3'd0, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd4, 1, 0, 1, 2'd1, 3'd0, 1, 0, 0, 32'd2, 7));
        // sw retires from MEM with a write
        run("sw", 32'h0020A223, 1'b0, 4, 16'b1111, 16'b1001, 16'b1000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd3, 1, 0, 0, 2'd0, 3'd1, 1, 1, 1, 32'd3, 4));
        // beq taken / not taken
        run("beq_t", 32'h00000463, 1'b1, 3, 16'b111, 16'b001, 16'b000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd2, 1, 1, 0, 2'd0, 3'd2, 0, 0, 0, 32'd4, 3));
        run("beq_n", 32'h00000463, 1'b0, 3, 16'b111, 16'b001, 16'b000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd2, 1, 0, 0, 2'd0, 3'd2, 0, 0, 0, 32'd5, 3));
        // lui writes back the immediate
        run("lui", 32'h000010B7, 1'b0, 4, 16'b1111, 16'b0001, 16'b0000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd4, 1, 0, 1, 2'd2, 3'd3, 0, 0, 0, 32'd6, 4));
        // add (R-type) has no immediate
        run("add", 32'h002081B3, 1'b0, 4, 16'b1111, 16'b0001, 16'b0000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd4, 1, 0, 1, 2'd0, 3'd4, 0, 0, 0, 32'd7, 4));
        // illegal opcode halts and stays halted
        run("ill", 32'h0000007F, 1'b0, 5, 16'b11111, 16'b00001, 16'b00000,
            {3'd0, 3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd1, 3'd0}, 1'b0,
            mk(3'd0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 32'd0, 0));
        @(negedge clk);
        chk("halt_illegal", 32'(illegal),  32'd1);
        chk("halt_count",   retired_count, 32'd8);
        chk("halt_imm",     32'(imm_type), 32'd4);
        chk("halt_pc_we",   32'(pc_we),    32'd0);

        // reset out of HALT
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hrst_state",   32'(state),    32'd0);
        chk("hrst_illegal", 32'(illegal),  32'd0);
        chk("hrst_count",   retired_count, 32'd0);
        chk("hrst_mem_req", 32'(mem_req),  32'd0);

        // reset during a stalled fetch drops mem_req, then fetch restarts
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0; inst = 32'h00500093;
        @(negedge clk);
        chk("stall_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstc_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstn_mem_req", 32'(mem_req), 32'd0);
        chk("rstn_state",   32'(state),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("refetch_is_fetch", 32'(mem_is_fetch), 32'd1);
        @(posedge clk); #1;
        // the cycle just sampled was the first FETCH cycle (mem_ready low)
        run("addi_re", 32'h00500093, 1'b0, 4, 16'b1111, 16'b0001, 16'b0000,
            {3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0}, 1'b1,
            mk(3'd4, 1, 0, 1, 2'd0, 3'd0, 1, 0, 0, 32'd0, 5));

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
